// File: rtl/egress_defs_pkg.sv
// Shared definitions for the egress drain arbiter: word/counter widths,
// port-index width and the drain FSM state encoding.
package egress_defs_pkg;

    localparam int DATA_W = 10;   // [9:8] class, [7:0] payload, passed through untouched
    localparam int CNT_W  = 5;    // per-port drained-word counter width (wraps)
    localparam int NPORT  = 4;    // output FIFOs 4..7
    localparam int PORT_W = 2;    // source-port index width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_CAP  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way rotating-priority arbiter, purely combinational.
// The request at index ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
module rr_arbiter_4
    import egress_defs_pkg::*;
(
    input  logic [NPORT-1:0]  req,
    input  logic [PORT_W-1:0] ptr,
    output logic [PORT_W-1:0] grant,
    output logic              grant_valid
);

    logic [PORT_W-1:0] sel    [NPORT];
    logic [NPORT-1:0]  rot;
    logic [PORT_W-1:0] offset;

    // Rotate the request vector so bit 0 is the port at the pointer.
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rot
        assign sel[gi] = ptr + PORT_W'(gi);
        assign rot[gi] = req[sel[gi]];
    end

    // Lowest set bit of the rotated vector is the winning distance from the pointer.
    always_comb begin
        offset = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (rot[i]) offset = PORT_W'(i);
        end
    end

    assign grant       = ptr + offset;
    assign grant_valid = |req;

endmodule

// File: rtl/egress_drain_arbiter.sv
// Egress drain arbiter: pops output FIFOs 4..7 round-robin, one word in
// flight at a time, and presents each word on a valid/ready stream tagged
// with its source port.
// Optional build macro EGRESS_COUNTERS_EN adds per-port drained-word
// counters and the idx/req query port; without it cnt_valid/cnt_out are 0.
module egress_drain_arbiter
    import egress_defs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NPORT-1:0]  empty_in,
    input  logic [DATA_W-1:0] fifo_data_in0,
    input  logic [DATA_W-1:0] fifo_data_in1,
    input  logic [DATA_W-1:0] fifo_data_in2,
    input  logic [DATA_W-1:0] fifo_data_in3,
    output logic              pop4,
    output logic              pop5,
    output logic              pop6,
    output logic              pop7,
    output logic [DATA_W-1:0] data_out,
    output logic [PORT_W-1:0] port_out,
    output logic              valid_out,
    input  logic              ready_in,
    input  logic [PORT_W-1:0] idx,
    input  logic              req,
    output logic              cnt_valid,
    output logic [CNT_W-1:0]  cnt_out
);

    state_t            state_reg;
    logic [PORT_W-1:0] grant_reg;
    logic [PORT_W-1:0] rr_ptr_reg;
    logic [NPORT-1:0]  pop_reg;
    logic [DATA_W-1:0] data_reg;
    logic [PORT_W-1:0] port_reg;
    logic              valid_reg;

    logic [PORT_W-1:0] arb_grant;
    logic              arb_valid;
    logic [DATA_W-1:0] fifo_word [NPORT];
    logic              accept;

    assign fifo_word[0] = fifo_data_in0;
    assign fifo_word[1] = fifo_data_in1;
    assign fifo_word[2] = fifo_data_in2;
    assign fifo_word[3] = fifo_data_in3;

    // A word leaves the stage on the handshake edge in S_HOLD.
    assign accept = (state_reg == S_HOLD) && valid_reg && ready_in;

    rr_arbiter_4 u_arb (
        .req         (~empty_in),
        .ptr         (rr_ptr_reg),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Drain FSM: grant, pop for one cycle, capture the FIFO word, hold until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            pop_reg    <= '0;
            data_reg   <= '0;
            port_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (enable && arb_valid) begin
                        grant_reg <= arb_grant;
                        pop_reg   <= NPORT'(1) << arb_grant;
                        state_reg <= S_POP;
                    end
                end
                S_POP: begin
                    pop_reg   <= '0;
                    state_reg <= S_CAP;
                end
                S_CAP: begin
                    // FIFO read data is valid the cycle after its pop.
                    data_reg  <= fifo_word[grant_reg];
                    port_reg  <= grant_reg;
                    valid_reg <= 1'b1;
                    state_reg <= S_HOLD;
                end
                S_HOLD: begin
                    if (accept) begin
                        valid_reg  <= 1'b0;
                        rr_ptr_reg <= grant_reg + PORT_W'(1);
                        state_reg  <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign pop4      = pop_reg[0];
    assign pop5      = pop_reg[1];
    assign pop6      = pop_reg[2];
    assign pop7      = pop_reg[3];
    assign data_out  = data_reg;
    assign port_out  = port_reg;
    assign valid_out = valid_reg;

`ifdef EGRESS_COUNTERS_EN
    logic [CNT_W-1:0] cnt_reg [NPORT];
    logic             cnt_valid_reg;
    logic [CNT_W-1:0] cnt_out_reg;

    // Per-port drained-word counters; wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NPORT; i++) cnt_reg[i] <= '0;
        end else if (accept) begin
            cnt_reg[grant_reg] <= cnt_reg[grant_reg] + CNT_W'(1);
        end
    end

    // Query response one cycle after req; same-cycle increment shows the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_valid_reg <= 1'b0;
            cnt_out_reg   <= '0;
        end else begin
            cnt_valid_reg <= req;
            if (req) cnt_out_reg <= cnt_reg[idx];
        end
    end

    assign cnt_valid = cnt_valid_reg;
    assign cnt_out   = cnt_out_reg;
`else
    // Query port is inert when counters are not built.
    logic unused_query;
    assign unused_query = ^{idx, req};
    assign cnt_valid    = 1'b0;
    assign cnt_out      = '0;
`endif

endmodule

// File: tb/tb_egress_drain_arbiter.sv
// Self-checking bench for egress_drain_arbiter: behavioural FIFO models,
// a scoreboard of popped words checked at each handshake, a table of
// single-port transactions and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_egress_drain_arbiter;
    import egress_defs_pkg::*;

`ifdef EGRESS_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef logic [PORT_W+DATA_W-1:0] sb_t;

    typedef struct {
        logic [PORT_W-1:0] port;
        logic [DATA_W-1:0] word;
        logic [PORT_W-1:0] exp_port;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset, enable, ready_in, req;
    logic [PORT_W-1:0] idx;
    logic [NPORT-1:0]  empty_in;
    logic [DATA_W-1:0] fd [NPORT];
    logic pop4, pop5, pop6, pop7, valid_out, cnt_valid;
    logic [DATA_W-1:0] data_out;
    logic [PORT_W-1:0] port_out;
    logic [CNT_W-1:0]  cnt_out;

    logic [DATA_W-1:0] mem [NPORT][256];
    int push_cnt [NPORT] = '{0, 0, 0, 0};
    int pop_cnt  [NPORT] = '{0, 0, 0, 0};
    sb_t sb [$];
    int  pop_hist [$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NPORT; gi++) begin : g_empty
        assign empty_in[gi] = (push_cnt[gi] == pop_cnt[gi]);
    end

    egress_drain_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable), .empty_in(empty_in),
        .fifo_data_in0(fd[0]), .fifo_data_in1(fd[1]),
        .fifo_data_in2(fd[2]), .fifo_data_in3(fd[3]),
        .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
        .data_out(data_out), .port_out(port_out), .valid_out(valid_out),
        .ready_in(ready_in), .idx(idx), .req(req),
        .cnt_valid(cnt_valid), .cnt_out(cnt_out)
    );

    // FIFO models: a pop presents the head word on the next cycle; the scoreboard gets it too.
    always @(posedge clk) begin
        logic [NPORT-1:0] pops;
        pops = {pop7, pop6, pop5, pop4};
        if (pops != '0) begin
            n_tests++;
            if ($countones(pops) != 1) begin
                n_fail++;
                $display("FAIL one_pop: got pops=%b required one-hot", pops);
            end
            for (int p = 0; p < NPORT; p++) begin
                if (pops[p]) begin
                    n_tests++;
                    if (push_cnt[p] == pop_cnt[p]) begin
                        n_fail++;
                        $display("FAIL pop_empty: got pop on empty FIFO%0d required no pop", p + 4);
                    end
                    fd[p] <= mem[p][pop_cnt[p] % 256];
                    sb.push_back({PORT_W'(p), mem[p][pop_cnt[p] % 256]});
                    pop_cnt[p] <= pop_cnt[p] + 1;
                    pop_hist.push_back(p);
                end
            end
        end
    end

    // Scoreboard: every accepted word must match the oldest popped word.
    always @(negedge clk) begin
        if (reset && valid_out && ready_in) begin
            sb_t exp;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_accept: got port=%0d data=%h required no word", port_out, data_out);
            end else begin
                exp = sb.pop_front();
                if ({port_out, data_out} !== exp) begin
                    n_fail++;
                    $display("FAIL sb_word: got port=%0d data=%h required port=%0d data=%h",
                             port_out, data_out, exp[PORT_W+DATA_W-1:DATA_W], exp[DATA_W-1:0]);
                end else begin
                    $display("[TB] accept port=%0d data=%h", port_out, data_out);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic [DATA_W-1:0] w);
        mem[p][push_cnt[p] % 256] = w;
        push_cnt[p] = push_cnt[p] + 1;
    endtask

    task automatic wait_valid(input string name, input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (valid_out) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            tick();
            if (push_cnt == pop_cnt && sb.size() == 0 && !valid_out) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic query(input logic [PORT_W-1:0] i, input logic [CNT_W-1:0] exp);
        req = 1'b1;
        idx = i;
        tick();
        req = 1'b0;
        @(negedge clk);
        check("cnt_valid_resp", 32'(cnt_valid), 32'(CNT_EN));
        check("cnt_out_resp", 32'(cnt_out), CNT_EN ? 32'(exp) : 32'd0);
        $display("[TB] query idx=%0d cnt_valid=%0b cnt_out=%0d", i, cnt_valid, cnt_out);
        @(negedge clk);
        check("cnt_valid_idle", 32'(cnt_valid), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        vec_t vecs [5];
        int   exp_order [5];
        int   base;
        logic [DATA_W-1:0] held;

        vecs[0] = '{port: 2'd0, word: 10'h155, exp_port: 2'd0, exp_data: 10'h155};
        vecs[1] = '{port: 2'd1, word: 10'h2AA, exp_port: 2'd1, exp_data: 10'h2AA};
        vecs[2] = '{port: 2'd2, word: 10'h0F0, exp_port: 2'd2, exp_data: 10'h0F0};
        vecs[3] = '{port: 2'd3, word: 10'h3C3, exp_port: 2'd3, exp_data: 10'h3C3};
        vecs[4] = '{port: 2'd2, word: 10'h10F, exp_port: 2'd2, exp_data: 10'h10F};
        exp_order = '{0, 1, 2, 3, 0};

        reset = 1'b0; enable = 1'b1; ready_in = 1'b1; req = 1'b0; idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_pops", 32'({pop7, pop6, pop5, pop4}), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_port", 32'(port_out), 32'd0);
        check("rst_cnt_valid", 32'(cnt_valid), 32'd0);
        check("rst_cnt_out", 32'(cnt_out), 32'd0);
        reset = 1'b1;
        tick();

        // Single-port transactions from the table.
        for (int v = 0; v < 5; v++) begin
            push(vecs[v].port, vecs[v].word);
            wait_valid("vec_valid_timeout", 10);
            check("vec_data", 32'(data_out), 32'(vecs[v].exp_data));
            check("vec_port", 32'(port_out), 32'(vecs[v].exp_port));
            check("vec_pop_port", 32'(pop_hist[pop_hist.size() - 1]), 32'(vecs[v].exp_port));
            wait_drain("vec_drain_timeout", 20);
        end

        // Exact latency: empty drop in cycle 0, pop5 in cycle 1, valid_out in cycle 3.
        push(1, 10'h2A5);
        @(negedge clk);
        check("lat_c0_pop5", 32'(pop5), 32'd0);
        @(negedge clk);
        check("lat_c1_pop5", 32'(pop5), 32'd1);
        @(negedge clk);
        check("lat_c2_pop5", 32'(pop5), 32'd0);
        check("lat_c2_valid", 32'(valid_out), 32'd0);
        @(negedge clk);
        check("lat_c3_valid", 32'(valid_out), 32'd1);
        check("lat_c3_data", 32'(data_out), 32'h2A5);
        check("lat_c3_port", 32'(port_out), 32'd1);
        wait_drain("lat_drain_timeout", 20);
        query(2'd1, 5'd2);

        // Reset asserted while a word is held: everything clears immediately.
        ready_in = 1'b0;
        push(2, 10'h1E1);
        wait_valid("hold_valid_timeout", 10);
        #2;
        reset = 1'b0;
        #1;
        check("amid_valid", 32'(valid_out), 32'd0);
        check("amid_pops", 32'({pop7, pop6, pop5, pop4}), 32'd0);
        check("amid_data", 32'(data_out), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ready_in = 1'b1;
        tick();
        query(2'd1, 5'd0);

        // All four non-empty: grants rotate 4,5,6,7,4.
        base = pop_hist.size();
        push(0, 10'h011); push(0, 10'h044);
        push(1, 10'h122); push(2, 10'h233); push(3, 10'h344);
        wait_drain("rr_drain_timeout", 60);
        for (int k = 0; k < 5; k++) begin
            check("rr_order", 32'(pop_hist[base + k]), 32'(exp_order[k]));
        end
        query(2'd0, 5'd2);
        query(2'd3, 5'd1);

        // Backpressure: word held stable for 10 cycles and no new pop meanwhile.
        ready_in = 1'b0;
        push(2, 10'h3A5);
        push(3, 10'h155);
        wait_valid("bp_valid_timeout", 10);
        held = data_out;
        check("bp_first_data", 32'(held), 32'h3A5);
        base = pop_hist.size();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(valid_out), 32'd1);
            check("bp_data", 32'(data_out), 32'(held));
        end
        check("bp_no_pop", 32'(pop_hist.size()), 32'(base));
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        wait_drain("bp_drain_timeout", 30);
        check("bp_next_port", 32'(pop_hist[pop_hist.size() - 1]), 32'd3);

        // Counter wrap: 33 words from FIFO4 leave counter[0] at 1.
        do_reset();
        for (int w = 0; w < 33; w++) push(0, DATA_W'(w * 7 + 3));
        wait_drain("wrap_drain_timeout", 400);
        query(2'd0, 5'd1);
        query(2'd1, 5'd0);

        // enable dropped during the pop cycle: word completes, no further grants.
        push(1, 10'h2C3);
        push(2, 10'h0A5);
        begin
            bit seen_pop;
            seen_pop = 1'b0;
            for (int c = 0; c < 10 && !seen_pop; c++) begin
                tick();
                if (pop5) begin
                    enable = 1'b0;
                    seen_pop = 1'b1;
                end
            end
            check("en_pop_seen", 32'(seen_pop), 32'd1);
        end
        base = pop_hist.size();
        wait_valid("en_valid_timeout", 10);
        check("en_data", 32'(data_out), 32'h2C3);
        check("en_port", 32'(port_out), 32'd1);
        repeat (20) @(negedge clk);
        check("en_no_new_pop", 32'(pop_hist.size()), 32'(base + 1));
        check("en_fifo6_pending", 32'(empty_in[2]), 32'd0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_drain("en_drain_timeout", 30);
        check("en_resume_port", 32'(pop_hist[pop_hist.size() - 1]), 32'd2);

        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
